plab4_net_router_output_ctrl: RTL and testbench

Output-port controller for the ring router: shares one router output port among its three input controllers (prev, term, next) with round-robin arbitration. It also owns the credit count for the downstream input queue. Each input controller asserts a one-hot-per-port request. This block returns grants, drives the crossbar select and output valid, and exports `num_free` to the adjacent input controllers for their bubble flow-control check. One instance sits on each of the three router output ports.

---
 rtl/plab4_net_router_output_ctrl_pkg.sv | 10 +
 rtl/plab4_net_round_robin_arb3.sv | 24 ++
 rtl/plab4_net_router_output_ctrl.sv | 40 ++++
 tb/tb_plab4_net_router_output_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/plab4_net_router_output_ctrl_pkg.sv
// plab4_net_router_output_ctrl_pkg: shared port indices and request width for the ring router output ports
package plab4_net_router_output_ctrl_pkg;
  localparam int REQ_W = 3;
  localparam logic [1:0] PORT_PREV = 2'd0;
  localparam logic [1:0] PORT_TERM = 2'd1;
  localparam logic [1:0] PORT_NEXT = 2'd2;
  function automatic logic [1:0] onehot_to_port(input logic [REQ_W-1:0] g);
    return g[PORT_TERM] ? PORT_TERM : g[PORT_NEXT] ? PORT_NEXT : PORT_PREV;
  endfunction
endpackage

// File: rtl/plab4_net_round_robin_arb3.sv
// plab4_net_round_robin_arb3: three-way round-robin arbiter with one-hot priority updated on fire
module plab4_net_round_robin_arb3
  import plab4_net_router_output_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             fire,
  input  logic [REQ_W-1:0] reqs,
  output logic [REQ_W-1:0] grants
);
  logic [REQ_W-1:0] prio, r, rot, g;
  assign r = reqs & {REQ_W{en}};
  // rotate so the priority requester sits at bit 0, pick the lowest set bit, rotate back
  always_comb begin
    rot = prio[0] ? r : prio[1] ? {r[0], r[2:1]} : {r[1:0], r[2]};
    g = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    grants = prio[0] ? g : prio[1] ? {g[1:0], g[2]} : {g[0], g[2:1]};
  end
  always_ff @(posedge clk) begin
    if (reset) prio <= 3'b001;
    else if (fire) prio <= {grants[1:0], grants[2]};
  end
endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// plab4_net_router_output_ctrl: round-robin output-port arbitration with downstream credit tracking
module plab4_net_router_output_ctrl
  import plab4_net_router_output_ctrl_pkg::*;
#(
  parameter int p_num_credits    = 3,
  parameter int p_num_free_nbits = 2
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [REQ_W-1:0]            reqs,
  output logic [REQ_W-1:0]            grants,
  output logic [1:0]                  xbar_sel,
  output logic                        out_val,
  input  logic                        credit_return,
  output logic [p_num_free_nbits-1:0] num_free
);
  localparam logic [p_num_free_nbits-1:0] FULL = p_num_free_nbits'(p_num_credits);
  logic [p_num_free_nbits-1:0] credits;
  plab4_net_round_robin_arb3 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (credits != '0),
    .fire  (out_val),
    .reqs  (reqs),
    .grants(grants)
  );
  assign out_val  = |grants;
  assign xbar_sel = onehot_to_port(grants);
  assign num_free = credits;
  always_ff @(posedge clk) begin
    if (reset) credits <= FULL;
    else if (credit_return && !out_val) credits <= (credits == FULL) ? credits : credits + 1'b1;
    else if (out_val && !credit_return) credits <= credits - 1'b1;
  end
  // a return with the queue already fully free means the downstream side miscounted
  always_ff @(posedge clk) begin
    if (!reset && credit_return && !out_val && credits == FULL)
      $warning("plab4_net_router_output_ctrl: credit return overflow, count held at %0d", credits);
  end
endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// tb_plab4_net_router_output_ctrl: directed checks of arbitration order, credit counting and reset
module tb_plab4_net_router_output_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] reqs;
  logic [2:0] grants;
  logic [1:0] xbar_sel;
  logic       out_val;
  logic       credit_return;
  logic [1:0] num_free;
  int checks = 0;
  int errors = 0;

  plab4_net_router_output_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .reqs         (reqs),
    .grants       (grants),
    .xbar_sel     (xbar_sel),
    .out_val      (out_val),
    .credit_return(credit_return),
    .num_free     (num_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int g, input int x, input int v, input int nf);
    chk({tag, " grants"}, int'(grants), g);
    chk({tag, " xbar_sel"}, int'(xbar_sel), x);
    chk({tag, " out_val"}, int'(out_val), v);
    chk({tag, " num_free"}, int'(num_free), nf);
  endtask

  task automatic drive(input logic rs, input logic [2:0] r, input logic cr);
    reset = rs;
    reqs = r;
    credit_return = cr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 3'b000, 1'b0);
    step();
    drive(1'b0, 3'b000, 1'b0);
    expect_out("reset", 0, 0, 0, 3);
    step();
    drive(1'b0, 3'b111, 1'b1);
    expect_out("rr0", 1, 0, 1, 3);
    step();
    expect_out("rr1", 2, 1, 1, 3);
    step();
    expect_out("rr2", 4, 2, 1, 3);
    step();
    expect_out("rr3", 1, 0, 1, 3);
    step();
    drive(1'b1, 3'b000, 1'b0);
    step();
    drive(1'b0, 3'b111, 1'b0);
    expect_out("drain0", 1, 0, 1, 3);
    step();
    expect_out("drain1", 2, 1, 1, 2);
    step();
    expect_out("drain2", 4, 2, 1, 1);
    step();
    expect_out("empty", 0, 0, 0, 0);
    drive(1'b0, 3'b111, 1'b1);
    expect_out("empty_ret", 0, 0, 0, 0);
    step();
    drive(1'b0, 3'b111, 1'b0);
    expect_out("refill", 1, 0, 1, 1);
    step();
    chk("after_refill num_free", int'(num_free), 0);
    drive(1'b0, 3'b000, 1'b1);
    step();
    step();
    drive(1'b0, 3'b010, 1'b0);
    expect_out("set_prio", 2, 1, 1, 2);
    step();
    drive(1'b0, 3'b011, 1'b1);
    expect_out("wrap", 1, 0, 1, 1);
    step();
    expect_out("wrap_next", 2, 1, 1, 1);
    step();
    chk("send_ret num_free", int'(num_free), 1);
    drive(1'b0, 3'b000, 1'b1);
    step();
    step();
    chk("full num_free", int'(num_free), 3);
    step();
    chk("overflow num_free", int'(num_free), 3);
    drive(1'b0, 3'b100, 1'b0);
    expect_out("pre0", 4, 2, 1, 3);
    step();
    drive(1'b0, 3'b001, 1'b0);
    expect_out("pre1", 1, 0, 1, 2);
    step();
    drive(1'b1, 3'b010, 1'b0);
    expect_out("in_reset", 2, 1, 1, 1);
    step();
    drive(1'b0, 3'b110, 1'b0);
    expect_out("post_reset", 2, 1, 1, 3);
    step();
    drive(1'b0, 3'b101, 1'b0);
    expect_out("post_reset2", 4, 2, 1, 2);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
